mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter_rr_arb2.sv | 27 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port-index constants, wait-counter width and a small one-hot helper.
// No ports; imported by the interface, the arbiter top and rr_arb2.
package mem_arbiter_pkg;

   // Arbiter FSM states; the encoding is fixed so it can be probed externally
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

   // Port indices used for the last-grant pointer and one-hot vectors
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Wait counter is wide enough for the largest legal timeout (255)
   localparam int CNT_W = 8;

   // One-hot vector selecting a single port
   function automatic logic [1:0] portMask(input logic port);
      return (port == PORT1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every handshake and memory-bus signal of the arbiter.
//   Requester side : iReq0/1, iWe0/1, iAddr0/1, iWData0/1 in;
//                    oAck0/1, oErr0/1, oRData, oBusy out
//   Memory side    : oMemRead, oMemWrite, oMemAddr, oMemWData out;
//                    iMemReady, iMemRData in
// Modport slave is the arbiter's view; modport master is the view of
// whatever drives the requests and plays the memory.
interface mem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   import mem_arbiter_pkg::*;

   logic              iReq0;
   logic              iReq1;
   logic              iWe0;
   logic              iWe1;
   logic [ADDR_W-1:0] iAddr0;
   logic [ADDR_W-1:0] iAddr1;
   logic [DATA_W-1:0] iWData0;
   logic [DATA_W-1:0] iWData1;
   logic              oAck0;
   logic              oAck1;
   logic              oErr0;
   logic              oErr1;
   logic [DATA_W-1:0] oRData;
   logic              oMemRead;
   logic              oMemWrite;
   logic [ADDR_W-1:0] oMemAddr;
   logic [DATA_W-1:0] oMemWData;
   logic              iMemReady;
   logic [DATA_W-1:0] iMemRData;
   logic              oBusy;

   modport slave (
      input  iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1,
      input  iMemReady, iMemRData,
      output oAck0, oAck1, oErr0, oErr1, oRData, oBusy,
      output oMemRead, oMemWrite, oMemAddr, oMemWData
   );

   modport master (
      output iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1,
      output iMemReady, iMemRData,
      input  oAck0, oAck1, oErr0, oErr1, oRData, oBusy,
      input  oMemRead, oMemWrite, oMemAddr, oMemWData
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-input round-robin grant selection (purely combinational).
//   req_i       : request from port 0 (bit 0) and port 1 (bit 1)
//   lastGrant_i : port that was granted most recently
//   grant_o     : one-hot grant, all zero when nobody requests
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       lastGrant_i,
   output logic [1:0] grant_o
);

   // A lone requester always wins; on contention the port that was not
   // granted last is favoured so the two ports alternate.
   always_comb begin
      grant_o = 2'b00;
      if (req_i[PORT0] && req_i[PORT1]) begin
         grant_o = portMask(~lastGrant_i);
      end else if (req_i[PORT0]) begin
         grant_o = portMask(PORT0);
      end else if (req_i[PORT1]) begin
         grant_o = portMask(PORT1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates two requesters (port 0: CPU control, port 1: DMA/debug) onto
// one single-access memory bus with a bounded wait for memory ready.
//   iCLK, iRST : clock and synchronous active-high reset
//   bus        : mem_arbiter_if.slave carrying both request ports, the
//                per-port ack/err pulses, read data, busy and the memory bus
// Parameters: DATA_W, ADDR_W bus widths; TIMEOUT (1..255) is the number of
// ACCESS cycles allowed before the access is aborted with an error.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic      iCLK,
   input logic      iRST,
   mem_arbiter_if.slave bus
);

   // The counter starts at 0 on the first ACCESS cycle, so the access is
   // out of time on the cycle where it holds TIMEOUT-1 (i.e. it would reach
   // TIMEOUT on the next increment). Ready on that same cycle still wins.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   arbState_t         state_q;
   logic              lastGrant_q;
   logic              port_q;
   logic              we_q;
   logic [CNT_W-1:0]  waitCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wData_q;
   logic [DATA_W-1:0] rData_q;
   logic              memRead_q;
   logic              memWrite_q;
   logic [1:0]        ack_q;
   logic [1:0]        err_q;

   logic [1:0]        grant_d;
   logic              grantPort_d;
   logic              grantWe_d;
   logic [ADDR_W-1:0] grantAddr_d;
   logic [DATA_W-1:0] grantWData_d;

   rr_arb2 uArb (
      .req_i       ({bus.iReq1, bus.iReq0}),
      .lastGrant_i (lastGrant_q),
      .grant_o     (grant_d)
   );

   // Select the signals of whichever port the arbiter is granting so the
   // FSM can latch them in a single step.
   always_comb begin
      grantPort_d  = grant_d[PORT1];
      grantWe_d    = bus.iWe0;
      grantAddr_d  = bus.iAddr0;
      grantWData_d = bus.iWData0;
      if (grantPort_d == PORT1) begin
         grantWe_d    = bus.iWe1;
         grantAddr_d  = bus.iAddr1;
         grantWData_d = bus.iWData1;
      end
   end

   // Main FSM. All outputs are registers so iMemReady never reaches an
   // output combinationally. Strobes rise on the grant edge and fall on the
   // edge that leaves ACCESS; the ack/err pulse lives for the RESP cycle
   // only, and RESP always returns to IDLE to leave a one-cycle bus gap.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q     <= IDLE;
         lastGrant_q <= PORT1;
         port_q      <= PORT0;
         we_q        <= 1'b0;
         waitCnt_q   <= '0;
         addr_q      <= '0;
         wData_q     <= '0;
         rData_q     <= '0;
         memRead_q   <= 1'b0;
         memWrite_q  <= 1'b0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d != 2'b00) begin
                  port_q      <= grantPort_d;
                  lastGrant_q <= grantPort_d;
                  we_q        <= grantWe_d;
                  addr_q      <= grantAddr_d;
                  wData_q     <= grantWData_d;
                  memRead_q   <= ~grantWe_d;
                  memWrite_q  <= grantWe_d;
                  waitCnt_q   <= '0;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus.iMemReady) begin
                  memRead_q  <= 1'b0;
                  memWrite_q <= 1'b0;
                  rData_q    <= we_q ? '0 : bus.iMemRData;
                  ack_q      <= portMask(port_q);
                  err_q      <= 2'b00;
                  state_q    <= RESP;
               end else if (waitCnt_q == LAST_WAIT) begin
                  memRead_q  <= 1'b0;
                  memWrite_q <= 1'b0;
                  rData_q    <= '0;
                  ack_q      <= portMask(port_q);
                  err_q      <= portMask(port_q);
                  state_q    <= RESP;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            RESP: begin
               ack_q   <= 2'b00;
               err_q   <= 2'b00;
               rData_q <= '0;
               state_q <= IDLE;
            end
            default: begin
               memRead_q  <= 1'b0;
               memWrite_q <= 1'b0;
               ack_q      <= 2'b00;
               err_q      <= 2'b00;
               rData_q    <= '0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   // Drive the interface straight from the registers
   always_comb begin
      bus.oAck0     = ack_q[PORT0];
      bus.oAck1     = ack_q[PORT1];
      bus.oErr0     = err_q[PORT0];
      bus.oErr1     = err_q[PORT1];
      bus.oRData    = rData_q;
      bus.oMemRead  = memRead_q;
      bus.oMemWrite = memWrite_q;
      bus.oMemAddr  = addr_q;
      bus.oMemWData = wData_q;
      bus.oBusy     = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The bench plays both requesters and
// a memory whose ready arrives on a chosen ACCESS cycle (or never). Each
// request pushes its expected completion into a scoreboard queue; a monitor
// pops and compares whenever an ack pulse appears.
module tb_mem_arbiter;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 15;

   typedef struct {
      bit          port;
      bit          err;
      logic [31:0] rdata;
      int          len;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
   } exp_t;

   logic iCLK = 1'b0;
   logic iRST;

   exp_t        sb[$];
   exp_t        monE;
   int          errCount = 0;
   int          checkCount = 0;
   int          readyAt = -1;
   int          strobeCycles = 0;
   int          runLen = 0;
   logic [31:0] seenAddr = '0;
   logic [31:0] seenWData = '0;
   bit          seenWe = 1'b0;
   bit          expPtr = 1'b1;
   bit          pend0 = 1'b0;
   bit          pend1 = 1'b0;
   int          lat0 = 0;
   int          lat1 = 0;

   mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   always #5 iCLK = ~iCLK;

   // Memory contents as seen by the bench
   function automatic logic [31:0] memValue(input logic [31:0] a);
      return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
   endfunction

   // Memory model: strobeCycles is the 0-based index of the current ACCESS
   // cycle; ready is raised on index readyAt.
   always @(posedge iCLK) begin
      if (bus.oMemRead || bus.oMemWrite) strobeCycles <= strobeCycles + 1;
      else strobeCycles <= 0;
   end
   assign bus.iMemReady = (bus.oMemRead || bus.oMemWrite) && (strobeCycles == readyAt);
   assign bus.iMemRData = memValue(bus.oMemAddr);

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checkCount++;
      if (got !== want) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Queue the expected completion of one access
   task automatic pushExp(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ready);
      exp_t e;
      e.port  = port;
      e.err   = (ready < 0) || (ready >= TIMEOUT);
      e.len   = e.err ? TIMEOUT : ready + 1;
      e.rdata = (e.err || we) ? 32'h0 : memValue(addr);
      e.addr  = addr;
      e.we    = we;
      e.wdata = wdata;
      sb.push_back(e);
   endtask

   // Raise requests just after a rising edge and queue expectations in the
   // order round-robin arbitration must serve them.
   task automatic applyStimulus(input bit r0, input bit r1, input bit we0, input bit we1,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input int ready);
      bit first;
      first = (r0 && r1) ? ~expPtr : (r0 ? 1'b0 : 1'b1);
      if (first == 1'b0) pushExp(1'b0, we0, a0, d0, ready);
      else pushExp(1'b1, we1, a1, d1, ready);
      if (r0 && r1) begin
         if (first == 1'b0) pushExp(1'b1, we1, a1, d1, ready);
         else pushExp(1'b0, we0, a0, d0, ready);
         expPtr = ~first;
      end else begin
         expPtr = first;
      end
      readyAt = ready;
      @(posedge iCLK);
      #1;
      bus.iReq0 = r0; bus.iWe0 = we0; bus.iAddr0 = a0; bus.iWData0 = d0;
      bus.iReq1 = r1; bus.iWe1 = we1; bus.iAddr1 = a1; bus.iWData1 = d1;
      pend0 = r0;
      pend1 = r1;
   endtask

   // Wait (bounded) for the pending acks, dropping each request on its ack.
   // Latencies count falling edges from the request; the IDLE cycle is 1.
   task automatic waitAcks();
      int cyc = 0;
      while ((pend0 || pend1) && cyc < 200) begin
         @(negedge iCLK);
         cyc++;
         if (pend0 && bus.oAck0) begin bus.iReq0 = 1'b0; pend0 = 1'b0; lat0 = cyc; end
         if (pend1 && bus.oAck1) begin bus.iReq1 = 1'b0; pend1 = 1'b0; lat1 = cyc; end
      end
      if (pend0 || pend1) begin
         checkOutput("ackTimeout", {pend1, pend0}, 2'b00);
         bus.iReq0 = 1'b0;
         bus.iReq1 = 1'b0;
         pend0 = 1'b0;
         pend1 = 1'b0;
      end
   endtask

   // Monitor: strobe exclusivity and idle-output checks every cycle, and a
   // scoreboard pop with full comparison on every ack pulse.
   always @(negedge iCLK) begin
      if (bus.oMemRead || bus.oMemWrite) begin
         checkOutput("strobeExcl", bus.oMemRead & bus.oMemWrite, 1'b0);
         runLen++;
         seenAddr  = bus.oMemAddr;
         seenWData = bus.oMemWData;
         seenWe    = bus.oMemWrite;
      end
      if (bus.oAck0 || bus.oAck1) begin
         if (sb.size() == 0) begin
            checkOutput("spuriousAck", {bus.oAck1, bus.oAck0}, 2'b00);
         end else begin
            monE = sb.pop_front();
            checkOutput("ackPort", {bus.oAck1, bus.oAck0}, monE.port ? 2'b10 : 2'b01);
            checkOutput("errBits", {bus.oErr1, bus.oErr0},
                        monE.err ? (monE.port ? 2'b10 : 2'b01) : 2'b00);
            checkOutput("rData", bus.oRData, monE.rdata);
            checkOutput("strobeLen", runLen, monE.len);
            checkOutput("memAddr", seenAddr, monE.addr);
            checkOutput("memKind", seenWe, monE.we);
            checkOutput("memWData", seenWData, monE.wdata);
            checkOutput("busyResp", bus.oBusy, 1'b1);
         end
         runLen = 0;
      end else begin
         checkOutput("rDataIdle", bus.oRData, 32'h0);
         checkOutput("errIdle", {bus.oErr1, bus.oErr0}, 2'b00);
         if (!(bus.oMemRead || bus.oMemWrite)) runLen = 0;
      end
   end

   initial begin
      iRST = 1'b1;
      bus.iReq0 = 1'b0; bus.iWe0 = 1'b0; bus.iAddr0 = '0; bus.iWData0 = '0;
      bus.iReq1 = 1'b0; bus.iWe1 = 1'b0; bus.iAddr1 = '0; bus.iWData1 = '0;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      // Reset state
      checkOutput("rstBusy", bus.oBusy, 1'b0);
      checkOutput("rstStrobes", {bus.oMemRead, bus.oMemWrite}, 2'b00);
      checkOutput("rstAcks", {bus.oAck1, bus.oAck0}, 2'b00);
      checkOutput("rstMemAddr", bus.oMemAddr, 32'h0);
      checkOutput("rstMemWData", bus.oMemWData, 32'h0);
      iRST = 1'b0;

      // Contention straight after reset: port 0, one IDLE gap, then port 1
      applyStimulus(1, 1, 0, 1, 32'h80, 32'h84, 32'h0, 32'hCAFE_0001, 0);
      waitAcks();
      checkOutput("contLat0", lat0, 3);
      checkOutput("contGap", lat1 - lat0, 3);
      // Repeated contention serves port 0 again
      applyStimulus(1, 1, 1, 0, 32'h90, 32'h94, 32'h1111_2222, 32'h0, 1);
      waitAcks();

      // Single read, ready on the 2nd ACCESS cycle: ack on cycle 4
      applyStimulus(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 1);
      waitAcks();
      checkOutput("readLatency", lat0, 4);
      // Port 0 was granted last, so contention now favours port 1
      applyStimulus(1, 1, 0, 0, 32'hA0, 32'hA4, 32'h0, 32'h0, 0);
      waitAcks();

      // Timeout on a port 1 write: 15 strobe cycles then error ack
      applyStimulus(0, 1, 0, 1, 32'h0, 32'h100, 32'h0, 32'h5555_AAAA, -1);
      waitAcks();
      checkOutput("timeoutLatency", lat1, TIMEOUT + 2);
      // Ready on the last allowed ACCESS cycle still succeeds
      applyStimulus(1, 0, 0, 0, 32'h140, 32'h0, 32'h0, 32'h0, TIMEOUT - 1);
      waitAcks();

      // Requester changes its address after grant; latched values must hold
      applyStimulus(1, 0, 0, 0, 32'h200, 32'h0, 32'h1234, 32'h0, 4);
      repeat (2) @(negedge iCLK);
      bus.iAddr0 = 32'h999;
      bus.iWData0 = 32'hFFFF;
      waitAcks();
      checkOutput("addrHeld", bus.oMemAddr, 32'h200);

      // Reset during ACCESS of a port 0 read: no ack, strobes drop at once
      readyAt = -1;
      @(posedge iCLK);
      #1;
      bus.iReq0 = 1'b1; bus.iWe0 = 1'b0; bus.iAddr0 = 32'h300;
      repeat (3) @(negedge iCLK);
      checkOutput("preRstStrobe", bus.oMemRead, 1'b1);
      iRST = 1'b1;
      @(negedge iCLK);
      checkOutput("rstMidStrobes", {bus.oMemRead, bus.oMemWrite}, 2'b00);
      checkOutput("rstMidBusy", bus.oBusy, 1'b0);
      iRST = 1'b0;
      bus.iReq0 = 1'b0;
      expPtr = 1'b1;
      repeat (3) @(negedge iCLK);
      // Pointer is back at its reset value, so port 0 wins
      applyStimulus(1, 1, 0, 0, 32'h310, 32'h314, 32'h0, 32'h0, 2);
      waitAcks();

      // Random traffic; the monitor keeps checking strobe exclusivity
      for (int i = 0; i < 20; i++) begin
         bit r0, r1;
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         applyStimulus(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {$urandom_range(0, 255), 4'h0}, {$urandom_range(0, 255), 4'h4},
                       $urandom, $urandom, int'($urandom_range(0, TIMEOUT + 1)));
         waitAcks();
      end

      repeat (3) @(negedge iCLK);
      checkOutput("sbEmpty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
